btn_debounce: RTL and testbench

//   Front-end conditioner for the five raw board push-buttons (u/d/l/r/c), placed

---
 rtl/btn_debounce.sv | 154 +++++++++++++++
 tb/tb_btn_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Per-button two-flop synchroniser, stable-count debounce,
//                one-cycle press/release pulses and typematic auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int N_BTN         = 5,
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pin_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_repeat_o
);

    // Debounce counter only ever needs to reach STABLE_CYCLES-1.
    localparam int unsigned c_DCNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    // Hold counter serves both the initial delay and the repeat period.
    localparam int unsigned c_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned c_HCNT_W   = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;

    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST   = c_DCNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_DELAY_LAST  = c_HCNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_HCNT_W-1:0] c_PERIOD_LAST = c_HCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HOLD_DELAY  = 2'd1,
        ST_HOLD_REPEAT = 2'd2
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic                r_s1;
        logic                r_s2;
        logic                r_level;
        logic [c_DCNT_W-1:0] r_dcnt;
        state_t              r_state;
        state_t              w_state_nxt;
        logic [c_HCNT_W-1:0] r_hcnt;
        logic [c_HCNT_W-1:0] w_hcnt_nxt;
        logic                w_tick;
        logic                w_flip;
        logic                w_rise;
        logic                w_fall;
        logic                r_press;
        logic                r_release;
        logic                r_repeat;

        // The level flips on the edge where the mismatch has lasted STABLE_CYCLES edges.
        assign w_flip = (r_s2 != r_level) && (r_dcnt == c_DCNT_LAST);
        assign w_rise = w_flip &&  r_s2;
        assign w_fall = w_flip && !r_s2;

        // Synchroniser and stable-count debounce filter.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                r_s1 <= btn_pin_i[i];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == c_DCNT_LAST) begin
                    r_level <= r_s2;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end

        // Repeat FSM state and hold counter register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
            end
        end

        // Repeat FSM next state; a release edge overrides any coincident tick.
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_tick      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HOLD_DELAY;
                        w_hcnt_nxt  = '0;
                    end
                end
                ST_HOLD_DELAY: begin
                    if (r_hcnt == c_DELAY_LAST) begin
                        w_tick      = 1'b1;
                        w_hcnt_nxt  = '0;
                        w_state_nxt = ST_HOLD_REPEAT;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                ST_HOLD_REPEAT: begin
                    if (r_hcnt == c_PERIOD_LAST) begin
                        w_tick     = 1'b1;
                        w_hcnt_nxt = '0;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
            if (w_fall) begin
                w_state_nxt = ST_IDLE;
                w_hcnt_nxt  = '0;
                w_tick      = 1'b0;
            end
        end

        // Registered pulses aligned with the cycle the debounced level changes.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                r_repeat  <= w_rise | w_tick;
            end
        end

        assign btn_level_o[i]   = r_level;
        assign btn_press_o[i]   = r_press;
        assign btn_release_o[i] = r_release;
        assign btn_repeat_o[i]  = r_repeat;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce: directed scenarios
//                with literal expectations plus randomized pin activity
//                compared every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce;

    localparam int c_N = 5;
    localparam int c_S = 4;
    localparam int c_D = 10;
    localparam int c_P = 3;

    logic           clk;
    logic           rst;
    logic [c_N-1:0] pin;
    logic [c_N-1:0] level;
    logic [c_N-1:0] press;
    logic [c_N-1:0] release_p;
    logic [c_N-1:0] repeat_p;

    int vectors     = 0;
    int miscompares = 0;

    // Model outputs
    logic [c_N-1:0] e_level;
    logic [c_N-1:0] e_press;
    logic [c_N-1:0] e_rel;
    logic [c_N-1:0] e_rep;

    // Model state: sample delay line, run length of the delayed sample,
    // believed level, and edges elapsed since the press (-1 when not held).
    int m_p1[c_N];
    int m_p2[c_N];
    int m_prev[c_N];
    int m_run[c_N];
    int m_lvl[c_N];
    int m_age[c_N];

    btn_debounce #(
        .N_BTN        (c_N),
        .STABLE_CYCLES(c_S),
        .REPEAT_DELAY (c_D),
        .REPEAT_PERIOD(c_P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pin_i    (pin),
        .btn_level_o  (level),
        .btn_press_o  (press),
        .btn_release_o(release_p),
        .btn_repeat_o (repeat_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_N-1:0] act, input logic [c_N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model.
    task automatic model_step();
        for (int i = 0; i < c_N; i++) begin
            if (rst) begin
                m_p1[i] = 0; m_p2[i] = 0; m_prev[i] = 0; m_run[i] = 0;
                m_lvl[i] = 0; m_age[i] = -1;
                e_level[i] = 1'b0; e_press[i] = 1'b0; e_rel[i] = 1'b0; e_rep[i] = 1'b0;
            end else begin
                int d;
                bit pr, rl, rp;
                d = m_p2[i];
                m_p2[i] = m_p1[i];
                m_p1[i] = int'(pin[i]);
                if (d == m_prev[i]) begin
                    if (m_run[i] <= c_S) m_run[i]++;
                end else begin
                    m_run[i] = 1;
                end
                m_prev[i] = d;
                pr = 1'b0; rl = 1'b0; rp = 1'b0;
                if (d != m_lvl[i] && m_run[i] == c_S) begin
                    m_lvl[i] = d;
                    pr = (d == 1);
                    rl = (d == 0);
                end
                if (pr) begin
                    m_age[i] = 0;
                    rp = 1'b1;
                end else if (rl) begin
                    m_age[i] = -1;
                end else if (m_age[i] >= 0) begin
                    m_age[i]++;
                    rp = (m_age[i] == c_D) || (m_age[i] > c_D && ((m_age[i] - c_D) % c_P) == 0);
                end
                e_level[i] = (m_lvl[i] == 1);
                e_press[i] = pr;
                e_rel[i]   = rl;
                e_rep[i]   = rp;
            end
        end
    endtask

    // Model update on every edge and full-output comparison just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("level",   level,             e_level);
            check("press",   press,             e_press);
            check("release", release_p,         e_rel);
            check("repeat",  repeat_p,          e_rep);
            check("excl",    press & release_p, '0);
        end
    end

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rep_edge(input int k);
        return k inside {6, 16, 19, 22, 25, 28, 31, 34};
    endfunction

    initial begin
        int prob;
        rst = 1'b1;
        pin = '0;
        repeat (3) edge_tick();
        check("reset_level", level, '0);
        check("reset_pulse", press | release_p | repeat_p, '0);
        rst = 1'b0;

        // Hold pin[1] for edges 1..30, then release.
        pin = 5'b00010;
        for (int k = 1; k <= 45; k++) begin
            edge_tick();
            check("hold_level1", {4'b0, level[1]}, {4'b0, (k >= 6 && k < 36) ? 1'b1 : 1'b0});
            check("hold_press",  press,     (k == 6)  ? 5'b00010 : 5'b00000);
            check("hold_rel",    release_p, (k == 36) ? 5'b00010 : 5'b00000);
            check("hold_rep",    repeat_p,  rep_edge(k) ? 5'b00010 : 5'b00000);
            if (k == 30) pin = 5'b00000;
        end

        // Bounce on pin[2]: high 3, low 1, high 3, low.
        pin = 5'b00100;
        for (int k = 1; k <= 20; k++) begin
            edge_tick();
            check("bounce_level", level, '0);
            check("bounce_pulse", press | release_p | repeat_p, '0);
            pin = (k <= 2 || (k >= 4 && k <= 6)) ? 5'b00100 : 5'b00000;
        end

        // Simultaneous press, lone release of bit 2, then reset mid-hold.
        pin = 5'b10101;
        for (int k = 1; k <= 32; k++) begin
            edge_tick();
            if (k <= 8)
                check("sim_press", press, (k == 6) ? 5'b10101 : 5'b00000);
            if (k >= 9 && k <= 22)
                check("sim_rel", release_p, (k == 14) ? 5'b00100 : 5'b00000);
            if (k == 23) begin
                check("rst_level",  level,     '0);
                check("rst_press",  press,     '0);
                check("rst_rel",    release_p, '0);
                check("rst_repeat", repeat_p,  '0);
            end
            if (k >= 24)
                check("rst_repress", press, (k == 29) ? 5'b10001 : 5'b00000);
            if (k == 8)  pin = 5'b10001;
            if (k == 22) rst = 1'b1;
            if (k == 23) rst = 1'b0;
        end

        pin = '0;
        repeat (15) edge_tick();

        // Randomized pins alternating between bouncy and long-hold phases.
        for (int n = 0; n < 3000; n++) begin
            edge_tick();
            prob = ((n / 400) % 2 == 0) ? 3 : 30;
            for (int i = 0; i < c_N; i++)
                if ($urandom_range(0, prob - 1) == 0) pin[i] = ~pin[i];
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        edge_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
